// File: rtl/cla_seq_pkg.sv
// Shared constants for the sequential CLA adder: FSM encoding, slice width
// and the counter-width helper.
package cla_seq_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int SLICE_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cla_nibble.sv
// Purely combinational 4-bit carry-lookahead slice; every carry is a
// flat generate/propagate sum of products of the slice inputs.
module cla_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g = a & b;
  assign p = a ^ b;

  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_seq_adder.sv
// WIDTH-bit adder that reuses one 4-bit CLA slice per nibble, LSB first,
// with valid/ready handshakes. Define CLA_SEQ_OVF_EN to add the ovf output.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef CLA_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / SLICE_W;
  localparam int CNT_W   = (clog2(NIBBLES) < 1) ? 1 : clog2(NIBBLES);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q, rdy_d;
`ifdef CLA_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [3:0]       slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_next;

  cla_nibble u_slice (
    .a    (a_sh_q[3:0]),
    .b    (b_sh_q[3:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New nibble enters at the top so the LSB nibble lands at bit 0 after the last pass.
  generate
    if (NIBBLES == 1) begin : g_one
      assign sum_next = slice_sum;
    end else begin : g_many
      assign sum_next = {slice_sum, sum_sh_q[WIDTH-1:SLICE_W]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
`ifdef CLA_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_valid && rdy_q) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = sum_next;
        a_sh_d   = a_sh_q >> SLICE_W;
        b_sh_d   = b_sh_q >> SLICE_W;
        carry_d  = slice_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NIBBLES - 1)) begin
          state_d = DONE;
`ifdef CLA_SEQ_OVF_EN
          ovf_d   = slice_cout ^ (a_sh_q[3] ^ b_sh_q[3] ^ slice_sum[3]);
`endif
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
`ifdef CLA_SEQ_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
`ifdef CLA_SEQ_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // After the final pass the carry register holds the carry out of bit WIDTH-1.
  assign start_ready  = rdy_q;
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q == RUN) || (state_q == DONE);
  assign sum          = sum_sh_q;
  assign cout         = carry_q;
`ifdef CLA_SEQ_OVF_EN
  assign ovf          = ovf_q;
`endif

endmodule
